// File: rtl/ps2_key_event_queue.sv
// PS/2 Set-2 prefix sequencer (E0/F0/E1) feeding a show-ahead FIFO of 10-bit key events
// {ext, rel, code}. Raises a sticky overflow flag on drops and an irq pulse per queued event.
module ps2_key_event_queue #(
    parameter int unsigned DEPTH_LOG2     = 3,
    parameter logic [15:0] PREFIX_TIMEOUT = 16'd32000
) (
    input  logic                  clk32,
    input  logic                  reset_n,
    input  logic                  code_valid,
    input  logic [7:0]            code_in,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [9:0]            rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  irq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_REL     = 3'd2;
    localparam logic [2:0] S_EXT_REL = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [15:0] tmo_q, tmo_d;
    logic        push;
    logic [9:0]  push_data;
    logic        is_err;

    assign is_err = (code_in == 8'h00) || (code_in == 8'hFF);

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        push_data = 10'd0;
        if (code_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (code_in == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (code_in == 8'hF0) begin
                        state_d = S_REL;
                    end else if (code_in == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end else if (!is_err) begin
                        push      = 1'b1;
                        push_data = {2'b00, code_in};
                    end
                end
                S_EXT: begin
                    if (code_in == 8'hF0) begin
                        state_d = S_EXT_REL;
                    end else if (code_in != 8'hE0) begin
                        state_d   = S_IDLE;
                        push      = !is_err;
                        push_data = {2'b10, code_in};
                    end
                end
                S_REL: begin
                    if (code_in != 8'hF0) begin
                        state_d   = S_IDLE;
                        push      = !is_err;
                        push_data = {2'b01, code_in};
                    end
                end
                S_EXT_REL: begin
                    state_d   = S_IDLE;
                    push      = !is_err;
                    push_data = {2'b11, code_in};
                end
                S_PAUSE: begin
                    // The whole 8-byte pause sequence collapses into a single marker entry.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d   = S_IDLE;
                        push      = 1'b1;
                        push_data = {2'b10, 8'hE1};
                    end
                end
                default: state_d = S_IDLE;
            endcase
            tmo_d = (state_d != S_IDLE) ? PREFIX_TIMEOUT : 16'd0;
        end else if (state_q != S_IDLE) begin
            if (tmo_q == 16'd0) begin
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            skip_q  <= 3'd0;
            tmo_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;
    logic [9:0]            mem [2**DEPTH_LOG2];
    logic                  empty, full, pop, push_ok, drop;

    assign level    = wr_ptr_q - rd_ptr_q;
    assign empty    = (level == '0);
    // level never exceeds the depth, so its top bit alone marks full.
    assign full     = level[DEPTH_LOG2];
    assign pop      = rd_en && !empty;
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_valid = !empty;
    assign rd_data  = empty ? 10'd0 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk32) begin
        if (push_ok) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            irq <= push_ok;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Randomized and directed bench for ps2_key_event_queue, checked against a queue-based
// model of the key-event rules.
module tb_ps2_key_event_queue;

    localparam int unsigned DEPTH_LOG2 = 3;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam int          TO         = 32000;

    logic                clk32 = 1'b0;
    logic                reset_n = 1'b0;
    logic                code_valid = 1'b0;
    logic [7:0]          code_in = 8'h00;
    logic                rd_en = 1'b0;
    logic                rd_valid;
    logic [9:0]          rd_data;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic                clr_overflow = 1'b0;
    logic                irq;

    ps2_key_event_queue #(
        .DEPTH_LOG2     (DEPTH_LOG2),
        .PREFIX_TIMEOUT (16'(TO))
    ) dut (
        .clk32        (clk32),
        .reset_n      (reset_n),
        .code_valid   (code_valid),
        .code_in      (code_in),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .irq          (irq)
    );

    always #5 clk32 = ~clk32;

    int checks = 0;
    int errors = 0;

    // Reference model: queued events plus a description of the pending prefix.
    int q[$];
    bit m_active, m_ext, m_rel, m_ovf, m_irq;
    int m_pause, m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0; m_ext = 0; m_rel = 0; m_ovf = 0; m_irq = 0;
        m_pause = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] c, input bit rd, input bit clr);
        bit do_push = 0;
        int ent = 0;
        bit pop = rd && (q.size() > 0);
        if (v) begin
            if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) begin do_push = 1; ent = 'h2E1; end
            end else if (!m_active) begin
                if (c == 8'hE0) begin m_active = 1; m_ext = 1; m_rel = 0; end
                else if (c == 8'hF0) begin m_active = 1; m_ext = 0; m_rel = 1; end
                else if (c == 8'hE1) m_pause = 7;
                else if (c != 8'h00 && c != 8'hFF) begin do_push = 1; ent = c; end
            end else begin
                if (c == 8'h00 || c == 8'hFF) m_active = 0;
                else if (c == 8'hF0 && !m_rel) m_rel = 1;
                else if (c == 8'hF0 && !m_ext) ;
                else if (c == 8'hE0 && m_ext && !m_rel) ;
                else begin
                    do_push = 1;
                    ent = (int'(m_ext) << 9) | (int'(m_rel) << 8) | int'(c);
                    m_active = 0;
                end
            end
            m_idle = 0;
        end else if (m_active || m_pause > 0) begin
            m_idle++;
            if (m_idle > TO) begin m_active = 0; m_pause = 0; end
        end
        if (pop) void'(q.pop_front());
        if (clr) m_ovf = 0;
        m_irq = 0;
        if (do_push) begin
            if (q.size() < DEPTH) begin q.push_back(ent); m_irq = 1; end
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
        check("level", 32'(level), 32'(q.size()));
        check("rd_data", 32'(rd_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic cycle(input bit v, input logic [7:0] c, input bit rd, input bit clr);
        code_valid = v; code_in = c; rd_en = rd; clr_overflow = clr;
        @(posedge clk32);
        model_step(v, c, rd, clr);
        #1;
        code_valid = 0; rd_en = 0; clr_overflow = 0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1, b, 0, 0);
        repeat (3) cycle(0, 8'h00, 0, 0);
    endtask

    task automatic drain();
        while (q.size() > 0) cycle(0, 8'h00, 1, 0);
    endtask

    initial begin
        int irq_cnt;
        model_reset();
        repeat (3) @(posedge clk32);
        #1;
        compare_all();
        @(negedge clk32);
        reset_n = 1'b1;

        // Make then break of the same key.
        irq_cnt = 0;
        cycle(1, 8'h1C, 0, 0); irq_cnt += int'(irq);
        repeat (31) begin cycle(0, 8'h00, 0, 0); irq_cnt += int'(irq); end
        cycle(1, 8'hF0, 0, 0);
        repeat (31) cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h1C, 0, 0); irq_cnt += int'(irq);
        repeat (31) begin cycle(0, 8'h00, 0, 0); irq_cnt += int'(irq); end
        check("make_break_level", 32'(level), 32'd2);
        check("make_break_irqs", 32'(irq_cnt), 32'd2);
        check("make_head", 32'(rd_data), 32'h01C);
        drain();

        // Extended make and extended break.
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_make_head", 32'(rd_data), 32'h275);
        cycle(0, 8'h00, 1, 0);
        check("ext_break_head", 32'(rd_data), 32'h375);
        cycle(0, 8'h00, 1, 0);
        check("ext_drained", 32'(rd_valid), 32'd0);

        // Pause sequence collapses to one marker.
        irq_cnt = 0;
        foreach (q[i]) ;
        begin
            logic [7:0] pause_seq [8];
            pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            for (int i = 0; i < 8; i++) begin
                cycle(1, pause_seq[i], 0, 0); irq_cnt += int'(irq);
                cycle(0, 8'h00, 0, 0); irq_cnt += int'(irq);
            end
        end
        check("pause_irqs", 32'(irq_cnt), 32'd1);
        check("pause_entry", 32'(rd_data), 32'h2E1);
        send(8'h1C);
        check("after_pause_level", 32'(level), 32'd2);
        drain();

        // Abandoned prefix after timeout, then error bytes in IDLE.
        cycle(1, 8'hE0, 0, 0);
        repeat (TO + 1) cycle(0, 8'h00, 0, 0);
        send(8'h1C);
        check("timeout_entry", 32'(rd_data), 32'h01C);
        drain();
        send(8'h00); send(8'hFF);
        check("err_bytes_empty", 32'(level), 32'd0);

        // Overflow and full-with-pop behaviour.
        for (int i = 0; i < DEPTH + 1; i++) send(8'h15 + 8'(i));
        check("ovf_level", 32'(level), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(rd_data), 32'h015);
        cycle(1, 8'h40, 1, 0);
        check("full_pushpop_level", 32'(level), 32'(DEPTH));
        check("full_pushpop_irq", 32'(irq), 32'd1);
        cycle(0, 8'h00, 0, 1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        drain();

        // Asynchronous reset mid-sequence.
        send(8'h1C); send(8'h32); send(8'h21);
        cycle(1, 8'hF0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk32);
        reset_n = 1'b1;
        send(8'h1C);
        check("post_reset_entry", 32'(rd_data), 32'h01C);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bit v, rd, clr;
            logic [7:0] b;
            int r;
            v = ($urandom % 3) == 0;
            r = $urandom % 10;
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = (($urandom % 4) == 0) ? 8'hE1 : 8'h1C;
                3: b = (($urandom % 2) == 0) ? 8'h00 : 8'hFF;
                default: b = 8'($urandom);
            endcase
            rd  = ($urandom % 4) == 0;
            clr = ($urandom % 50) == 0;
            cycle(v, b, rd, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Controller downstream of the PS/2 keyboard receiver. Consumes raw scancode bytes (one-cycle valid strobe plus an 8-bit code) and runs the Set-2 prefix sequencing for E0, F0 and E1.
- Each complete key event is collapsed into one 10-bit entry and buffered in a small FIFO for the CPU or bus side.
- Flags FIFO overflow and raises an interrupt pulse per queued event.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth. Depth = 2^DEPTH_LOG2; legal range 1..6.
- PREFIX_TIMEOUT, 16'd32000, cycles a partial prefix sequence may wait for its next byte before it is abandoned (1 ms at 32 MHz).

Ports:
- clk32  in  1  system clock, 32 MHz.
- reset_n  in  1  asynchronous active-low reset.
- code_valid  in  1  one-cycle strobe: code_in holds a new received byte.
- code_in  in  8  raw scancode byte.
- rd_en  in  1  pop strobe. Ignored when rd_valid=0.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  10  head entry {ext, rel, code[7:0]}. Show-ahead: valid whenever rd_valid=1.
- level  out  DEPTH_LOG2+1  number of queued entries.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clr_overflow  in  1  synchronous clear of overflow.
- irq  out  1  one-cycle pulse per successful push.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; FIFO empty, so rd_valid=0, level=0, rd_data=0.
  - overflow=0, irq=0, timeout counter=0, skip counter=0.
  - Reset mid-sequence discards any partial prefix and all queued entries.
- Prefix FSM. States: IDLE, EXT, REL, EXT_REL, PAUSE. Transitions happen only on cycles with code_valid=1.
  - IDLE:
    - E0 -> EXT.
    - F0 -> REL.
    - E1 -> PAUSE with skip=7.
    - 00 or FF (keyboard error/overrun) -> discarded, stay IDLE.
    - Any other byte -> push {0,0,code}.
  - EXT:
    - F0 -> EXT_REL.
    - E0 -> stay in EXT.
    - 00 or FF -> discard, go to IDLE.
    - Any other byte -> push {1,0,code}, go to IDLE.
  - REL:
    - F0 -> stay in REL.
    - 00 or FF -> discard, go to IDLE.
    - Any other byte -> push {0,1,code}, go to IDLE.
  - EXT_REL:
    - 00 or FF -> discard, go to IDLE.
    - Any other byte -> push {1,1,code}, go to IDLE.
  - PAUSE:
    - Every byte decrements skip.
    - The byte that takes skip from 1 to 0 pushes {1,0,8'hE1} (pause marker) and returns to IDLE.
    - No other entry is produced for the 8-byte pause sequence.
- Prefix timeout:
  - The 16-bit counter loads PREFIX_TIMEOUT on every accepted byte that leaves the FSM in a non-IDLE state.
  - It decrements each cycle while state!=IDLE.
  - When it reaches 0 with no byte arriving, the FSM returns to IDLE with no push.
  - If a byte arrives on the same cycle the counter hits 0, the byte is processed normally.
- Latency: push decided in cycle N (code_valid=1) -> entry written at the N edge -> rd_valid, level and irq update in cycle N+1. irq is high exactly one cycle.
- FIFO:
  - Pointers are DEPTH_LOG2+1 bits wide with natural wrap-around. level = wr_ptr - rd_ptr.
  - full when level == 2^DEPTH_LOG2; empty when level == 0.
  - Pop on rd_en && !empty: rd_ptr increments, and rd_data shows the next entry in the following cycle.
  - Push when full with no pop: entry dropped, overflow set, no irq, FSM still advances.
  - Push and pop in the same cycle when full: both occur, level unchanged, no overflow, irq pulses.
  - Push and pop in the same cycle when empty: only the push occurs (pop ignored because rd_valid=0), level becomes 1.
- Overflow:
  - Cleared by clr_overflow.
  - If clr_overflow and a new drop occur in the same cycle, the set wins (overflow=1).

Test Plan:
- Reset, then bytes 1C; F0 1C at 1 us spacing -> two entries, 0x01C then 0x11C. irq pulses twice. level ends at 2.
- Bytes E0 75; E0 F0 75 -> entries 0x275 then 0x375. Read both with rd_en -> rd_valid drops to 0, level returns to 0.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one entry, 0x2E1, with a single irq. Next byte 1C -> 0x01C, confirming the FSM is back in IDLE.
- Byte E0, idle 32001 cycles, then 1C -> entry 0x01C, not 0x21C. A byte of 00 or FF in IDLE -> no entry, no irq.
- DEPTH_LOG2=3: push 9 make codes without reading -> level=8 and overflow=1; the 9th code is absent and the head is still the 1st code. Pop concurrent with a 10th push -> level stays 8, no new overflow. Pulse clr_overflow -> overflow=0.
- Assert reset_n low mid-sequence after F0 with 3 entries queued -> outputs cleared asynchronously. After release, byte 1C yields 0x01C, with no stale release flag.
